// File: rtl/adc_sched_pkg.sv
// Shared types and widths for the ADC channel scheduler.
package adc_sched_pkg;

  localparam int CHAN_W = 3;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               found
);

  // Walk offsets from ptr outward; the first live request wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_chan_scheduler.sv
// Shares one ADC among NUM_REQ requesters: round-robin grant, settle the
// channel mux for SETTLE_CYCLES clocks, capture one result, return it.
module adc_chan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 250
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CHAN_W-1:0] req_chan,
  input  logic [DATA_W-1:0]         result,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [CHAN_W-1:0]         chan
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  rspValid_q, rspValid_d;
  logic [DATA_W-1:0]   rspData_q, rspData_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  pick;
  logic                found;
  logic [PTR_W-1:0]    pickIdx;
  logic [CHAN_W-1:0]   pickChan;
  logic                ownerLive;
  logic [PTR_W-1:0]    nextPtr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .found (found)
  );

  always_comb begin
    pickIdx  = '0;
    pickChan = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pickIdx  = PTR_W'(i);
        pickChan = req_chan[i*CHAN_W +: CHAN_W];
      end
    end
  end

  assign ownerLive = |(req & grant_q);
  assign nextPtr   = (idx_q == PTR_LAST) ? '0 : idx_q + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rspValid_q <= '0;
      rspData_q  <= '0;
      chan_q     <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      chan_q     <= chan_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // A dropped request from the owner aborts silently and still moves ptr on,
  // so one flaky requester cannot monopolise the ADC.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rspValid_d = '0;
    rspData_d  = rspData_q;
    chan_d     = chan_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          idx_d   = pickIdx;
          chan_d  = pickChan;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!ownerLive) begin
          grant_d = '0;
          ptr_d   = nextPtr;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        grant_d = '0;
        ptr_d   = nextPtr;
        state_d = IDLE;
        if (ownerLive) begin
          rspData_d  = result;
          rspValid_d = grant_q;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant     = grant_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign chan      = chan_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adc_chan_scheduler.sv
// Bench for adc_chan_scheduler (NUM_REQ=4, SETTLE_CYCLES=4) against a
// conversion-age reference model.
module tb_adc_chan_scheduler;

  localparam int NR = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [11:0] req_chan;
  logic [11:0] result;
  logic [3:0]  grant;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic        busy;
  logic [2:0]  chan;

  int errors = 0;
  int checks = 0;

  // Reference model: owner index (-1 when idle), clocks since grant, pointer.
  int          mOwner, mAge, mPtr, mValidIdx;
  logic [2:0]  mChan;
  logic [11:0] mData;
  logic [3:0]  expGrant, expValid;
  logic [11:0] expData;
  logic [2:0]  expChan;
  logic        expBusy;

  adc_chan_scheduler #(
    .NUM_REQ       (NR),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_chan  (req_chan),
    .result    (result),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .chan      (chan)
  );

  always #5 clk = ~clk;

  function automatic void modelOutputs();
    expGrant = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0;
    expValid = (mValidIdx >= 0) ? 4'(1 << mValidIdx) : 4'b0;
    expData  = mData;
    expChan  = mChan;
    expBusy  = (mOwner >= 0);
  endfunction

  function automatic void modelReset();
    mOwner = -1; mAge = 0; mPtr = 0; mValidIdx = -1;
    mChan = '0; mData = '0;
    modelOutputs();
  endfunction

  task automatic tick();
    logic [3:0]  r;
    logic [11:0] rc, res;
    @(posedge clk);
    r = req; rc = req_chan; res = result;
    mValidIdx = -1;
    if (mOwner < 0) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (mPtr + k) % NR;
        if (mOwner < 0 && r[j]) begin
          mOwner = j; mAge = 0; mChan = rc[3*j +: 3];
        end
      end
    end else if (!r[mOwner]) begin
      mPtr = (mOwner + 1) % NR; mOwner = -1;
    end else if (mAge == SC) begin
      mData = res; mValidIdx = mOwner; mPtr = (mOwner + 1) % NR; mOwner = -1;
    end else begin
      mAge++;
    end
    modelOutputs();
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset_n = 1'b0; req = '0; req_chan = '0; result = '0;
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b1111; req_chan = 12'($urandom); result = 12'($urandom);
    modelReset();
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, rsp_valid, rsp_data, chan, busy} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got grant=%b valid=%b data=%h chan=%0d busy=%b, want all zero",
               grant, rsp_valid, rsp_data, chan, busy);
    end
    req = '0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
    end
  endtask

  task automatic test_single();
    int grantCycles = 0;
    int validAt = -1;
    applyReset();
    req = 4'b0001; req_chan = 12'h001; result = 12'h950;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL single cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      if (grant == 4'b0001 && chan == 3'd1) grantCycles++;
      if (rsp_valid == 4'b0001 && rsp_data == 12'h950 && validAt < 0) validAt = k;
      if (expValid[0]) req = 4'b0000;
    end
    checks++;
    if (grantCycles !== SC + 1) begin
      errors++;
      $display("[TB] FAIL single_grant_len: got %0d cycles, want %0d", grantCycles, SC + 1);
    end
    checks++;
    if (validAt !== SC + 1) begin
      errors++;
      $display("[TB] FAIL single_latency: rsp_valid at cycle %0d, want %0d", validAt, SC + 1);
    end
  endtask

  task automatic test_all_four();
    int order[$];
    int at[$];
    int chans[$];
    logic [3:0] prevGrant = '0;
    applyReset();
    req = 4'b1111; req_chan = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 30; k++) begin
      result = 12'($urandom);
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL all_four cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      for (int i = 0; i < NR; i++) if (rsp_valid[i]) begin order.push_back(i); at.push_back(k); end
      if (grant != 4'b0 && prevGrant == 4'b0) chans.push_back(int'(chan));
      prevGrant = grant;
      req = req & ~expValid;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (((i < order.size()) ? order[i] : -1) !== i || ((i < chans.size()) ? chans[i] : -1) !== i) begin
        errors++;
        $display("[TB] FAIL all_four_order slot %0d: got idx=%0d chan=%0d, want %0d", i,
                 (i < order.size()) ? order[i] : -1, (i < chans.size()) ? chans[i] : -1, i);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (((i < at.size()) ? at[i] - at[i-1] : -1) !== SC + 2) begin
        errors++;
        $display("[TB] FAIL all_four_gap %0d: got %0d cycles, want %0d", i,
                 (i < at.size()) ? at[i] - at[i-1] : -1, SC + 2);
      end
    end
  endtask

  task automatic test_fairness();
    int seq[$];
    logic [3:0] prevGrant = '0;
    int want[4] = '{0, 2, 0, 2};
    applyReset();
    req = 4'b0101; req_chan = 12'($urandom); result = 12'($urandom);
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL fairness cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      if (grant != 4'b0 && prevGrant == 4'b0)
        for (int i = 0; i < NR; i++) if (grant[i]) seq.push_back(i);
      prevGrant = grant;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (((i < seq.size()) ? seq[i] : -1) !== want[i]) begin
        errors++;
        $display("[TB] FAIL fairness_order slot %0d: got %0d, want %0d", i,
                 (i < seq.size()) ? seq[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_abort();
    applyReset();
    req = 4'b0010; req_chan = 12'o0050; result = 12'h3C5;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL abort_setup cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      if (expValid[1]) req = 4'b0000;
    end
    req = 4'b0010; result = 12'h777;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) req = 4'b0000;
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL abort cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      if (k == 2) begin
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || rsp_valid !== 4'b0 || rsp_data !== 12'h3C5) begin
          errors++;
          $display("[TB] FAIL abort_result: got g=%b b=%b v=%b d=%h, want g=0000 b=0 v=0000 d=3c5",
                   grant, busy, rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    req = 4'b0001; req_chan = 12'h001; result = 12'h123;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, rsp_valid, rsp_data, chan, busy} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got grant=%b valid=%b data=%h chan=%0d busy=%b, want all zero",
               grant, rsp_valid, rsp_data, chan, busy);
    end
    modelReset();
    @(negedge clk);
    reset_n = 1'b1; req = 4'b1100; req_chan = 12'($urandom);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL reset_mid cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      if (k == 0) begin
        checks++;
        if (grant !== 4'b0100) begin
          errors++;
          $display("[TB] FAIL reset_mid_first_grant: got %b, want 0100", grant);
        end
      end
      req = req & ~expValid;
    end
  endtask

  task automatic test_chan_change();
    applyReset();
    req = 4'b0001; req_chan = 12'h001; result = 12'h0AB;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) req_chan[2:0] = 3'd3;
      if (k == 8) req = 4'b0001;
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL chan_change cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
      if (k <= SC + 1) begin
        checks++;
        if (chan !== 3'd1) begin
          errors++;
          $display("[TB] FAIL chan_hold cycle %0d: got chan=%0d, want 1", k, chan);
        end
      end
      if (expValid[0]) req = 4'b0000;
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (expValid[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && expGrant[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
      end
      req_chan = 12'($urandom);
      result   = 12'($urandom);
      tick();
      checks++;
      if ({grant, rsp_valid, rsp_data, chan, busy} !== {expGrant, expValid, expData, expChan, expBusy}) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got g=%b v=%b d=%h c=%0d b=%b, want g=%b v=%b d=%h c=%0d b=%b",
                 k, grant, rsp_valid, rsp_data, chan, busy, expGrant, expValid, expData, expChan, expBusy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_abort();
    test_reset_mid();
    test_chan_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_chan_scheduler.md
ADC_CHAN_SCHEDULER -- requirements
Module: adc_chan_scheduler

Interface
REQ-001 Parameter NUM_REQ SHALL default to 4; it is the number of requesters sharing the ADC (range 2..8).
REQ-002 Parameter SETTLE_CYCLES SHALL default to 250; it is the number of clocks chan is held before result is sampled (range 2..2^16-1).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  NUM_REQ  level request per requester; held high until that requester's rsp_valid bit pulses.
REQ-006 req_chan  input  NUM_REQ*3  ADC channel wanted by each requester; requester i uses bits [3i+2:3i].
REQ-007 grant  output  NUM_REQ  one-hot; marks the requester currently owning the ADC.
REQ-008 rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse; marks the requester whose conversion result is on rsp_data.
REQ-009 rsp_data  output  12  sampled ADC result; held until the next capture.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 chan  output  3  ADC channel selector.
REQ-012 result  input  12  ADC conversion result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SETTLE and CAPTURE.
REQ-014 In IDLE with any req bit high, the block SHALL pick index idx as the first requesting index at or after ptr, wrapping modulo NUM_REQ.
REQ-015 On that same edge it SHALL set grant to one-hot(idx), latch chan from req_chan of idx, clear the settle counter and enter SETTLE.
REQ-016 In SETTLE the counter SHALL increment each clock; on the edge where it equals SETTLE_CYCLES-1 the FSM SHALL enter CAPTURE, so chan is stable for exactly SETTLE_CYCLES clocks.
REQ-017 On the edge that leaves CAPTURE, the block SHALL:
- register result into rsp_data;
- set rsp_valid[idx] for exactly one cycle;
- clear grant;
- set ptr to (idx+1) mod NUM_REQ;
- return to IDLE.
REQ-018 Latency from grant assertion to the rsp_valid pulse SHALL be SETTLE_CYCLES+1 clocks.
REQ-019 The minimum gap between successive grants SHALL be one IDLE cycle, which coincides with the rsp_valid pulse.
REQ-020 chan SHALL hold its last value while IDLE.
REQ-021 req_chan changes after a grant SHALL be ignored until the next grant.
REQ-022 If req[idx] falls during SETTLE or CAPTURE, the block SHALL abort on the next edge:
- return to IDLE;
- clear grant;
- assert no rsp_valid;
- leave rsp_data unchanged;
- advance ptr to idx+1.
REQ-023 Requests from non-granted indices SHALL wait; when several are high, round-robin order from ptr SHALL guarantee that each is granted within NUM_REQ conversions.
REQ-024 Only one of grant and rsp_valid SHALL ever have a bit set, and at most one bit each.

Reset
REQ-025 While reset_n is low, the block SHALL force: state=IDLE, grant=0, rsp_valid=0, rsp_data=0, busy=0, chan=0, ptr=0, counter=0.
REQ-026 Reset asserted mid-conversion SHALL discard that conversion with no rsp_valid, and the first arbitration after release SHALL start from index 0.

Structure
REQ-027 Package adc_sched_pkg SHALL hold the state enum (IDLE, SETTLE, CAPTURE), CHAN_W=3 and DATA_W=12.
REQ-028 Sub-module rr_arbiter (combinational) SHALL take req and ptr and produce a one-hot pick plus a found flag; the FSM, counter and registers stay in adc_chan_scheduler.
REQ-029 The counter SHALL be $clog2(SETTLE_CYCLES) bits wide and SHALL never wrap inside SETTLE.

Verification
All scenarios use NUM_REQ=4 and SETTLE_CYCLES=4.
REQ-030 Single request: req=0001, req_chan0=1, result=0x950 -> chan=1 and grant=0001 for 5 cycles, then rsp_valid=0001 for one cycle with rsp_data=0x950.
REQ-031 All four request at once, with chan 0/1/2/3 -> grants in order 0,1,2,3, each rsp_valid 6 cycles apart, chan following 0,1,2,3.
REQ-032 Fairness: req0 held continuously plus req2 -> grants alternate 0,2,0,2.
REQ-033 Abort: req=0010 and granted, req1 dropped on SETTLE cycle 2 -> next cycle IDLE, grant=0, no rsp_valid, rsp_data unchanged.
REQ-034 Reset mid-SETTLE: reset_n low for 1 cycle -> all outputs 0 immediately; after release, req=1100 -> first grant=0100.
REQ-035 req_chan change during SETTLE: req_chan0 changed 1->3 on settle cycle 1 -> chan stays 1 until the conversion ends.
